// File: rtl/ad9361_ctrl_out_monitor.sv
// AD9361 CTRL_OUT monitor: two-flop synchronizer, per-bit glitch filter, and
// timestamped change events queued in a first-word-fall-through FIFO.

module ad9361_ctrl_out_filt_bit #(
   parameter int FILTER_CYCLES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic s2,
   output logic filt,
   output logic filt_nxt
);
   localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic             accept;

   // The new level is taken on the FILTER_CYCLES-th consecutive differing cycle.
   assign accept   = (s2 != filt) && (cnt == CNT_MAX);
   assign filt_nxt = accept ? s2 : filt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt  <= '0;
         filt <= 1'b0;
      end else begin
         filt <= filt_nxt;
         if ((s2 == filt) || accept) cnt <= '0;
         else                        cnt <= cnt + 1'b1;
      end
   end
endmodule

module ad9361_ctrl_out_monitor #(
   parameter int CTRL_WIDTH    = 8,
   parameter int TS_WIDTH      = 24,
   parameter int FIFO_AW       = 4,
   parameter int FILTER_CYCLES = 2
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic [CTRL_WIDTH-1:0]            ctrl_out,
   input  logic                             enable,
   input  logic [CTRL_WIDTH-1:0]            mask,
   output logic                             evt_valid,
   input  logic                             evt_ready,
   output logic [2*CTRL_WIDTH+TS_WIDTH-1:0] evt_data,
   output logic [FIFO_AW:0]                 fifo_level,
   output logic                             overflow,
   input  logic                             overflow_clr,
   output logic [CTRL_WIDTH-1:0]            ctrl_filt
);
   localparam int EW    = 2*CTRL_WIDTH + TS_WIDTH;
   localparam int DEPTH = 1 << FIFO_AW;

   logic [CTRL_WIDTH-1:0] s1, s2, filt, filt_nxt, chg;
   logic [TS_WIDTH-1:0]   ts;
   logic [EW-1:0]         mem [DEPTH];
   logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
   logic                  push_req, full, pop, push, drop;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1 <= '0;
         s2 <= '0;
         ts <= '0;
      end else begin
         s1 <= ctrl_out;
         s2 <= s1;
         ts <= ts + 1'b1;
      end
   end

   for (genvar i = 0; i < CTRL_WIDTH; i++) begin : g_filt
      ad9361_ctrl_out_filt_bit #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt (
         .clk      (clk),
         .resetn   (resetn),
         .s2       (s2[i]),
         .filt     (filt[i]),
         .filt_nxt (filt_nxt[i])
      );
   end

   assign ctrl_filt = filt;
   assign chg       = (filt_nxt ^ filt) & mask;
   assign push_req  = enable && (chg != '0);

   // A pop frees the slot at the same edge, so a full FIFO can still accept.
   assign full      = (fifo_level == (FIFO_AW+1)'(DEPTH));
   assign evt_valid = (fifo_level != '0);
   assign pop       = evt_valid && evt_ready;
   assign push      = push_req && (!full || pop);
   assign drop      = push_req && full && !pop;
   assign evt_data  = mem[rd_ptr];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {ts, chg, filt_nxt};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_level <= fifo_level + 1'b1;
         else if (!push && pop) fifo_level <= fifo_level - 1'b1;
         if (drop)              overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ad9361_ctrl_out_monitor.sv
// Directed bench for ad9361_ctrl_out_monitor; a narrow timestamp makes the wrap reachable.

module tb_ad9361_ctrl_out_monitor;
   localparam int CW   = 8;
   localparam int TS_W = 12;
   localparam int AW   = 4;
   localparam int EW   = 2*CW + TS_W;

   logic          clk = 1'b0;
   logic          resetn;
   logic [CW-1:0] ctrl_out, mask, ctrl_filt;
   logic          enable, evt_valid, evt_ready, overflow, overflow_clr;
   logic [EW-1:0] evt_data;
   logic [AW:0]   fifo_level;

   logic [TS_W-1:0] tb_ts;
   logic [EW-1:0]   exp_q [17];
   int n_vec = 0;
   int n_err = 0;

   ad9361_ctrl_out_monitor #(
      .CTRL_WIDTH(CW), .TS_WIDTH(TS_W), .FIFO_AW(AW), .FILTER_CYCLES(2)
   ) dut (
      .clk(clk), .resetn(resetn), .ctrl_out(ctrl_out), .enable(enable), .mask(mask),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
      .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr),
      .ctrl_filt(ctrl_filt)
   );

   always #5 clk = ~clk;

   // Reference free-running counter: value seen during the cycle before an edge.
   always @(posedge clk or negedge resetn)
      if (!resetn) tb_ts <= '0;
      else         tb_ts <= tb_ts + 1'b1;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [EW-1:0] got, input logic [EW-1:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0; ctrl_out = 8'hA5; enable = 1'b0; mask = 8'hFF;
      evt_ready = 1'b0; overflow_clr = 1'b0;
      #23;
      chk("rst_valid", EW'(evt_valid), '0);
      chk("rst_data", evt_data, '0);
      chk("rst_level", EW'(fifo_level), '0);
      chk("rst_ovf", EW'(overflow), '0);
      chk("rst_filt", EW'(ctrl_filt), '0);
      @(posedge clk); #1;
      resetn = 1'b1;
      tick(3);
      chk("rst_filt_e3", EW'(ctrl_filt), '0);
      tick(1);
      chk("rst_filt_e4", EW'(ctrl_filt), EW'(8'hA5));
      chk("rst_noevt", EW'(evt_valid), '0);
   endtask

   task automatic test_single_event;
      logic [TS_W-1:0] t;
      ctrl_out = 8'h00;
      tick(6);
      chk("single_filt0", EW'(ctrl_filt), '0);
      enable = 1'b1;
      ctrl_out = 8'h08;
      t = tb_ts + TS_W'(3);
      for (int i = 1; i <= 3; i++) begin
         tick(1);
         chk("single_lat_low", EW'(evt_valid), '0);
      end
      tick(1);
      chk("single_lat_high", EW'(evt_valid), 1);
      chk("single_data", evt_data, {t, 8'h08, 8'h08});
      tick(6);
      chk("single_one_evt", EW'(fifo_level), 1);
      chk("single_hold", evt_data, {t, 8'h08, 8'h08});
      enable = 1'b0; ctrl_out = 8'h00; evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      tick(6);
      chk("single_drained", EW'(fifo_level), 0);
      enable = 1'b1;
   endtask

   task automatic test_glitch;
      ctrl_out = 8'h01;
      tick(1);
      ctrl_out = 8'h00;
      tick(8);
      chk("glitch_noevt", EW'(evt_valid), '0);
      chk("glitch_filt", EW'(ctrl_filt), '0);
   endtask

   task automatic test_mask;
      logic [TS_W-1:0] t;
      mask = 8'hF0; ctrl_out = 8'h0F;
      tick(6);
      chk("mask_noevt", EW'(evt_valid), '0);
      chk("mask_filt", EW'(ctrl_filt), EW'(8'h0F));
      ctrl_out = 8'h1F;
      t = tb_ts + TS_W'(3);
      tick(4);
      chk("mask_evt", EW'(fifo_level), 1);
      chk("mask_data", evt_data, {t, 8'h10, 8'h1F});
      evt_ready = 1'b1; enable = 1'b0;
      tick(1);
      evt_ready = 1'b0; ctrl_out = 8'h00; mask = 8'hFF;
      tick(6);
      chk("mask_drained", EW'(fifo_level), 0);
      enable = 1'b1;
   endtask

   task automatic test_overflow;
      logic [CW-1:0] v;
      for (int k = 0; k < 17; k++) begin
         v = (k % 2 == 0) ? 8'h01 : 8'h00;
         ctrl_out = v;
         if (k < 16) exp_q[k] = {tb_ts + TS_W'(3), 8'h01, v};
         if (k == 16) begin
            tick(3);
            overflow_clr = 1'b1;
            tick(1);
            overflow_clr = 1'b0;
            chk("ovf_set_wins", EW'(overflow), 1);
            chk("ovf_level", EW'(fifo_level), 16);
            tick(3);
         end else begin
            tick(7);
         end
         if (k == 15) begin
            chk("ovf_full", EW'(fifo_level), 16);
            chk("ovf_not_yet", EW'(overflow), 0);
         end
      end
      evt_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         chk("ovf_drain", evt_data, exp_q[k]);
         tick(1);
      end
      evt_ready = 1'b0;
      chk("ovf_empty", EW'(fifo_level), 0);
      chk("ovf_sticky", EW'(overflow), 1);
      overflow_clr = 1'b1;
      tick(1);
      overflow_clr = 1'b0;
      chk("ovf_clr", EW'(overflow), 0);
   endtask

   task automatic test_back_to_back;
      logic [CW-1:0] v;
      for (int k = 0; k < 17; k++) begin
         v = (k % 2 == 0) ? 8'h00 : 8'h01;
         ctrl_out = v;
         exp_q[k] = {tb_ts + TS_W'(3), 8'h01, v};
         if (k == 16) begin
            tick(3);
            evt_ready = 1'b1;
            tick(1);
            evt_ready = 1'b0;
            chk("b2b_level", EW'(fifo_level), 16);
            chk("b2b_ovf", EW'(overflow), 0);
            tick(3);
         end else begin
            tick(7);
         end
      end
      evt_ready = 1'b1;
      for (int k = 1; k < 17; k++) begin
         chk("b2b_drain", evt_data, exp_q[k]);
         tick(1);
      end
      evt_ready = 1'b0;
      chk("b2b_empty", EW'(fifo_level), 0);
   endtask

   task automatic test_ts_wrap;
      int guard = 0;
      while (tb_ts != TS_W'((1 << TS_W) - 3) && guard < 5000) begin
         tick(1);
         guard++;
      end
      chk("wrap_reached", EW'(guard < 5000), 1);
      ctrl_out = 8'h01;
      tick(4);
      chk("wrap_valid", EW'(evt_valid), 1);
      chk("wrap_data", evt_data, {12'h000, 8'h01, 8'h01});
      chk("wrap_ovf", EW'(overflow), 0);
   endtask

   task automatic test_reset_mid;
      ctrl_out = 8'h00;
      tick(4);
      chk("mid_level", EW'(fifo_level), 2);
      #3 resetn = 1'b0;
      #1;
      chk("mid_valid", EW'(evt_valid), 0);
      chk("mid_level0", EW'(fifo_level), 0);
      chk("mid_data", evt_data, '0);
      chk("mid_filt", EW'(ctrl_filt), 0);
      @(posedge clk); #1;
      resetn = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_event();
      test_glitch();
      test_mask();
      test_overflow();
      test_back_to_back();
      test_ts_wrap();
      test_reset_mid();
      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ad9361_ctrl_out_monitor.md
Name: ad9361_ctrl_out_monitor

Overview:
Receive-side companion to the CTRL_IN/GPIO drive path. It samples the AD9361 CTRL_OUT status pins (8 bits, asynchronous to the fabric), synchronizes and glitch-filters them, and timestamps every change. Each change event goes into a small FIFO that software or a DMA-side consumer drains through a valid/ready handshake. One instance per AD9361 sits beside the system wrapper, on the same clock as the processor GPIO logic.

Parameters:
CTRL_WIDTH, 8, width of the CTRL_OUT bus
TS_WIDTH, 24, width of the free-running timestamp counter
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW (16)
FILTER_CYCLES, 2, consecutive synchronized cycles a new level must hold before it is accepted (>=1)

Ports:
clk  in  1  block clock
resetn  in  1  asynchronous active-low reset
ctrl_out  in  CTRL_WIDTH  raw AD9361 CTRL_OUT pins, asynchronous
enable  in  1  1 = generate events
mask  in  CTRL_WIDTH  1 = bit participates in event generation
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head
evt_data  out  2*CTRL_WIDTH+TS_WIDTH  {timestamp, changed_bits, new_value}
fifo_level  out  FIFO_AW+1  entries held, 0..2**FIFO_AW
overflow  out  1  sticky: an event was dropped
overflow_clr  in  1  single-cycle clear of overflow
ctrl_filt  out  CTRL_WIDTH  current filtered CTRL_OUT value

Behaviour:
- Reset: every register cleared. evt_valid=0, evt_data=0, fifo_level=0, overflow=0, ctrl_filt=0, timestamp=0, filter counters=0.
- Synchronizer: two flops s1 and s2 per bit. No logic between ctrl_out and s1.
- Filter, per bit i:
  - If s2[i]==filt[i]: cnt[i]<=0.
  - Otherwise cnt[i]++. When cnt[i]==FILTER_CYCLES-1 and the bit still differs: filt[i]<=s2[i], cnt[i]<=0.
  - Result: a pulse shorter than FILTER_CYCLES cycles at s2 never reaches filt.
  - FILTER_CYCLES=1: filt follows s2 one edge later.
- Latency: the pin is first sampled by s1 at edge E1. filt updates at edge E(2+FILTER_CYCLES), which is E4 at default. The event is written at that same edge, and evt_valid is high in the following cycle.
- Event generation:
  - upd = bits of filt that change at this edge.
  - chg = upd & mask.
  - If enable and chg!=0: push {ts, chg, filt_next}. ts is the counter value in the cycle before the edge. filt_next is the full new value, masked bits included.
  - Several bits changing at the same edge produce one event.
  - Changes on masked bits only update filt and ctrl_filt and produce no event.
- Timestamp: increments every cycle and wraps from 2**TS_WIDTH-1 to 0 with no flag.
- FIFO:
  - First-word-fall-through; evt_data always shows the head. evt_valid = (fifo_level!=0).
  - Pop on evt_valid & evt_ready.
  - Push while full and no pop: the event is dropped, overflow<=1, FIFO contents unchanged.
  - Push and pop together while full: both happen and the level stays at full.
  - Push and pop together while empty: push only (evt_valid was 0).
  - evt_data holds its value while evt_valid & !evt_ready.
- overflow is sticky. overflow_clr clears it. If a set and a clear happen in the same cycle, set wins.
- enable=0: no pushes. Filter, ctrl_filt and timestamp keep running. The FIFO keeps draining.
- An asynchronous reset mid-operation discards all FIFO contents immediately.

Test Plan:
1. Reset with ctrl_out=8'hA5 -> all outputs 0 during reset; after release, ctrl_filt=8'hA5 four edges later with no event (enable=0).
2. enable=1, mask=8'hFF, ctrl_filt=8'h00, set ctrl_out[3] high for 10 cycles -> exactly one event, evt_data={ts, 8'h08, 8'h08}; evt_valid rises at the 4th edge after the first sampling edge; ts equals the counter value in the cycle before that edge.
3. One-cycle glitch 8'h00->8'h01->8'h00 with FILTER_CYCLES=2 -> no event, ctrl_filt stays 8'h00.
4. mask=8'hF0, ctrl_out 8'h00->8'h0F -> no event and ctrl_filt=8'h0F; then ctrl_out 8'h0F->8'h1F -> one event with chg=8'h10, value=8'h1F.
5. evt_ready=0, 17 separated toggles of bit0 -> fifo_level=16, overflow=1, the first 16 events drain in order with increasing ts; overflow_clr -> overflow=0.
6. FIFO full, evt_ready=1 in the same cycle as a new event -> level stays 16, overflow stays 0, the new event appears last; timestamp preset near 2**24-1 -> ts wraps to 0 with no side effects.
